sram_like_data_responder: RTL

- Slave end of the data-side SRAM-like interface driven by the MEM stage: accepts req/addr_ok requests, performs byte-strobed writes and word reads on an internal word-addressed RAM, and returns in-order data_ok responses.
- Serves as the data-memory model in the CPU testbench and SoC shell.
- Programmable address and data latency plus optional pseudo-random stalls stress the MEM stage's wait_addr_ok/wait_data_ok handshake.

---
 rtl/sram_like_pkg.sv | 14 +
 rtl/sram_like_data_responder_resp_fifo.sv | 41 ++++
 rtl/sram_like_data_responder.sv | 65 ++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared types and constants for the SRAM-like data responder
package sram_like_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef struct packed {
    logic wr;
    logic [31:0] word;
  } resp_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/sram_like_data_responder_resp_fifo.sv
// resp_fifo: synchronous response FIFO; push+pop together keeps the count unchanged
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  resp_t din,
  output resp_t dout,
  output logic  full,
  output logic  empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  resp_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (do_pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/sram_like_data_responder.sv
// sram_like_data_responder: SRAM-like data-side slave with programmable latency, optional random stalls and in-order responses
module sram_like_data_responder
  import sram_like_pkg::*;
#(
  parameter int          AW_WORDS        = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          ADDR_LAT        = 0,
  parameter int          DATA_LAT        = 1,
  parameter bit          RAND_EN         = 1'b0,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int ACW = $clog2(ADDR_LAT + 2);
  localparam int DCW = $clog2(DATA_LAT + 2);
  logic [31:0] mem [2**AW_WORDS];
  logic [AW_WORDS-1:0] idx;
  logic [ACW-1:0] acnt;
  logic [DCW-1:0] dcnt;
  logic [15:0] lfsr;
  logic full, empty, accept, a_rdy, d_rdy;
  resp_t ent, head;
  logic unused_bits;
  assign idx = addr[AW_WORDS+1:2];
  // counters saturate at their latency, so equality means the wait is over
  assign a_rdy = acnt == ACW'(ADDR_LAT);
  assign d_rdy = dcnt == DCW'(DATA_LAT);
  assign addr_ok = req & ~rst & a_rdy & ~full & (~RAND_EN | lfsr[0]);
  assign accept = req & addr_ok;
  assign data_ok = ~rst & ~empty & d_rdy & (~RAND_EN | lfsr[1]);
  assign rdata = (data_ok & ~head.wr) ? head.word : '0;
  assign ent = '{wr: wr, word: mem[idx]};
  assign unused_bits = ^{size, addr[1:0], addr[31:AW_WORDS+2]};
  always_ff @(posedge clk) begin
    lfsr <= rst ? SEED : lfsr_next(lfsr);
    acnt <= (rst | ~req | accept) ? '0 : a_rdy ? acnt : acnt + 1'b1;
    dcnt <= (rst | empty | data_ok) ? '0 : d_rdy ? dcnt : dcnt + 1'b1;
  end
  // RAM is deliberately left out of reset so contents survive rst
  always_ff @(posedge clk) begin
    if (accept & wr)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (data_ok),
    .din  (ent),
    .dout (head),
    .full (full),
    .empty(empty)
  );
endmodule
